// File: rtl/trace_commit_buffer.sv
// trace_commit_buffer
// Captures one trace record per instruction retire (rising edge of
// instr_change) holding the retiring PC, IR and the last register-file write
// since the previous retire. Records are queued in a DEPTH-entry FIFO and
// streamed as 4-word packets over a valid/ready interface. Commits that find
// the FIFO full (with no pop on the same edge) are counted in a saturating
// drop counter.
//
// Ports:
//   clk_in, reset           clock, asynchronous active-low reset
//   trace_en                capture enable; disabled commits are ignored
//   instr_change            commit strobe, rising edge marks a retire
//   pc, instr               PC / IR of the retiring instruction
//   rf_we/rf_waddr/rf_wdata register-file write port being tracked
//   out_data/out_valid/out_ready/out_last  packet stream (W0..W3)
//   level                   records currently stored
//   drop_cnt                saturating count of commits lost to a full FIFO
//
// Optional feature: define TRACE_PC_FILTER_EN to add filt_lo/filt_hi; only
// commits with filt_lo <= pc <= filt_hi (unsigned) are captured.
module trace_commit_buffer #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int RADDR_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic                       clk_in,
  input  logic                       reset,
  input  logic                       trace_en,
  input  logic                       instr_change,
  input  logic [DATA_W-1:0]          pc,
  input  logic [DATA_W-1:0]          instr,
  input  logic                       rf_we,
  input  logic [RADDR_W-1:0]         rf_waddr,
  input  logic [DATA_W-1:0]          rf_wdata,
`ifdef TRACE_PC_FILTER_EN
  input  logic [DATA_W-1:0]          filt_lo,
  input  logic [DATA_W-1:0]          filt_hi,
`endif
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0]  pc;
    logic [DATA_W-1:0]  instr;
    logic               wb_v;
    logic [RADDR_W-1:0] wb_a;
    logic [DATA_W-1:0]  wb_d;
  } rec_t;

  typedef enum logic [2:0] {S_IDLE, S_W0, S_W1, S_W2, S_W3} state_t;

  logic               chg_q;
  logic               wb_v_q;
  logic [RADDR_W-1:0] wb_a_q;
  logic [DATA_W-1:0]  wb_d_q;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [CNT_W-1:0]   drop_cnt_q;
  state_t             state_q, state_d;
  rec_t               mem_q [DEPTH];

  logic commit_edge, pc_ok, capture, full, pop, push, drop, rf_hit;
  rec_t head;

  // A retire edge always consumes the tracker; the PC filter only decides
  // whether the record is kept.
  assign commit_edge = instr_change & ~chg_q & trace_en;
`ifdef TRACE_PC_FILTER_EN
  assign pc_ok = (pc >= filt_lo) && (pc <= filt_hi);
`else
  assign pc_ok = 1'b1;
`endif
  assign capture = commit_edge & pc_ok;
  assign rf_hit  = rf_we && (rf_waddr != '0);
  assign full    = (level_q == FULL_LVL);
  assign pop     = (state_q == S_W3) && out_ready;
  assign push    = capture && (!full || pop);
  assign drop    = capture && full && !pop;
  assign head    = mem_q[rd_ptr_q];

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      chg_q      <= 1'b0;
      wb_v_q     <= 1'b0;
      wb_a_q     <= '0;
      wb_d_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      drop_cnt_q <= '0;
      state_q    <= S_IDLE;
    end else begin
      chg_q   <= instr_change;
      level_q <= level_d;
      state_q <= state_d;
      // A write on the commit edge lands in the freshly cleared tracker.
      if (commit_edge) begin
        wb_v_q <= rf_hit;
        wb_a_q <= rf_hit ? rf_waddr : '0;
        wb_d_q <= rf_hit ? rf_wdata : '0;
      end else if (rf_hit) begin
        wb_v_q <= 1'b1;
        wb_a_q <= rf_waddr;
        wb_d_q <= rf_wdata;
      end
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (drop && (drop_cnt_q != '1)) drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  // NOTE: record storage has no reset; level/pointers alone define which
  // entries are valid, so clearing the array would only cost logic.
  always_ff @(posedge clk_in) begin
    if (push) mem_q[wr_ptr_q] <= '{pc: pc, instr: instr, wb_v: wb_v_q,
                                   wb_a: wb_a_q, wb_d: wb_d_q};
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // NOTE: every combinational output gets a default first so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    case (state_q)
      S_IDLE: if (level_q != '0) state_d = S_W0;
      S_W0: begin
        out_valid = 1'b1;
        out_data  = head.pc;
        if (out_ready) state_d = S_W1;
      end
      S_W1: begin
        out_valid = 1'b1;
        out_data  = head.instr;
        if (out_ready) state_d = S_W2;
      end
      S_W2: begin
        out_valid                = 1'b1;
        out_data[DATA_W-1]       = head.wb_v;
        out_data[RADDR_W-1:0]    = head.wb_a;
        if (out_ready) state_d = S_W3;
      end
      S_W3: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_data  = head.wb_d;
        // level_q still counts the record being popped here.
        if (out_ready) state_d = (level_q > LVL_W'(1)) ? S_W0 : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign level    = level_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_trace_commit_buffer.sv
// Directed testbench for trace_commit_buffer (default build, no PC filter).
module tb_trace_commit_buffer;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        trace_en;
  logic        instr_change;
  logic [31:0] pc, instr;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [4:0]  level;
  logic [15:0] drop_cnt;

  int errors = 0;
  int checks = 0;

  trace_commit_buffer dut (
    .clk_in(clk_in), .reset(reset), .trace_en(trace_en),
    .instr_change(instr_change), .pc(pc), .instr(instr),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .level(level), .drop_cnt(drop_cnt)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // One retire: strobe high for one edge, then low for one edge.
  task automatic commit(input logic [31:0] p, input logic [31:0] ir);
    pc = p; instr = ir; instr_change = 1'b1;
    tick();
    instr_change = 1'b0;
    tick();
  endtask

  task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
    rf_we = 1'b1; rf_waddr = a; rf_wdata = d;
    tick();
    rf_we = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 8 && !out_valid; i++) tick();
    check(tag, {31'd0, out_valid}, 32'd1);
  endtask

  // Expects W0 presented now, out_ready held high for four words.
  task automatic expect_packet(input string tag, input logic [31:0] p, input logic [31:0] ir,
                               input logic [31:0] w2, input logic [31:0] w3);
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".w0"}, out_data, p);
    check({tag, ".w0last"}, {31'd0, out_last}, 32'd0);
    tick();
    check({tag, ".w1"}, out_data, ir);
    tick();
    check({tag, ".w2"}, out_data, w2);
    tick();
    check({tag, ".w3"}, out_data, w3);
    check({tag, ".w3last"}, {31'd0, out_last}, 32'd1);
    tick();
  endtask

  initial begin
    logic [31:0] exp_w [4];
    reset = 1'b0; trace_en = 1'b0; instr_change = 1'b0;
    pc = '0; instr = '0; rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0;
    out_ready = 1'b0;
    #12;
    check("rst.valid", {31'd0, out_valid}, 32'd0);
    check("rst.last",  {31'd0, out_last}, 32'd0);
    check("rst.data",  out_data, 32'd0);
    check("rst.level", {27'd0, level}, 32'd0);
    check("rst.drop",  {16'd0, drop_cnt}, 32'd0);
    reset = 1'b1;
    trace_en = 1'b1;

    // Single commit with r1=5 written beforehand.
    rf_write(5'd1, 32'd5);
    pc = 32'h0040_0000; instr = 32'h2001_0005; instr_change = 1'b1;
    tick();
    check("t1.level_after_push", {27'd0, level}, 32'd1);
    check("t1.idle_after_push", {31'd0, out_valid}, 32'd0);
    instr_change = 1'b0;
    tick();
    check("t1.latency_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    expect_packet("t1", 32'h0040_0000, 32'h2001_0005, 32'h8000_0001, 32'h0000_0005);
    check("t1.level_end", {27'd0, level}, 32'd0);
    check("t1.valid_end", {31'd0, out_valid}, 32'd0);

    // Write only to r0, then commit: empty writeback fields.
    rf_write(5'd0, 32'hDEAD_BEEF);
    commit(32'h0000_0100, 32'h0000_0013);
    expect_packet("t2", 32'h0000_0100, 32'h0000_0013, 32'h0, 32'h0);

    // Capture disabled: commit ignored, not a drop.
    trace_en = 1'b0;
    commit(32'h0000_0200, 32'h0000_0013);
    check("t2b.level", {27'd0, level}, 32'd0);
    check("t2b.valid", {31'd0, out_valid}, 32'd0);
    trace_en = 1'b1;

    // Stalled consumer, 20 commits into a 16-deep FIFO.
    out_ready = 1'b0;
    for (int i = 0; i < 20; i++) commit(32'h1000 + 32'(4 * i), 32'hA000_0000 | 32'(i));
    check("t3.level_full", {27'd0, level}, 32'd16);
    check("t3.drops", {16'd0, drop_cnt}, 32'd4);

    // Walk the head packet to W3, then commit on the popping edge.
    out_ready = 1'b1;
    check("t4.w0", out_data, 32'h1000);
    tick(); tick(); tick();
    check("t4.at_w3", {31'd0, out_last}, 32'd1);
    pc = 32'h9000; instr = 32'h99; instr_change = 1'b1;
    tick();
    instr_change = 1'b0;
    check("t4.level_kept", {27'd0, level}, 32'd16);
    check("t4.drops_kept", {16'd0, drop_cnt}, 32'd4);
    for (int i = 1; i < 16; i++)
      expect_packet($sformatf("t4.pkt%0d", i), 32'h1000 + 32'(4 * i), 32'hA000_0000 | 32'(i), 32'h0, 32'h0);
    expect_packet("t4.pkt_new", 32'h9000, 32'h99, 32'h0, 32'h0);
    check("t4.level_end", {27'd0, level}, 32'd0);
    check("t4.valid_end", {31'd0, out_valid}, 32'd0);

    // Level-held strobe yields one commit; then ready toggled per cycle.
    out_ready = 1'b0;
    rf_write(5'd3, 32'h1234_5678);
    pc = 32'h2000; instr = 32'h33; instr_change = 1'b1;
    tick(); tick(); tick();
    instr_change = 1'b0;
    tick();
    check("t5.one_commit", {27'd0, level}, 32'd1);
    exp_w = '{32'h2000, 32'h33, 32'h8000_0003, 32'h1234_5678};
    for (int k = 0; k < 4; k++) begin
      out_ready = 1'b0;
      tick();
      check($sformatf("t5.stall_w%0d", k), out_data, exp_w[k]);
      out_ready = 1'b1;
      check($sformatf("t5.go_w%0d", k), out_data, exp_w[k]);
      tick();
    end
    check("t5.level_end", {27'd0, level}, 32'd0);
    check("t5.valid_end", {31'd0, out_valid}, 32'd0);

    // Reset during W2 with three records queued.
    out_ready = 1'b0;
    commit(32'h3000, 32'h1); commit(32'h3004, 32'h2); commit(32'h3008, 32'h3);
    check("t6.level3", {27'd0, level}, 32'd3);
    out_ready = 1'b1;
    tick(); tick();
    out_ready = 1'b0;
    check("t6.at_w2", out_data, 32'h0);
    reset = 1'b0;
    #1;
    check("t6.rst_valid", {31'd0, out_valid}, 32'd0);
    check("t6.rst_level", {27'd0, level}, 32'd0);
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    pc = 32'h4000; instr = 32'h44; instr_change = 1'b1;
    tick();
    instr_change = 1'b0;
    wait_valid("t6.wait");
    expect_packet("t6.pkt", 32'h4000, 32'h44, 32'h0, 32'h0);
    check("t6.level_end", {27'd0, level}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trace_commit_buffer.md
# trace_commit_buffer

Synthesizable instruction-commit trace capture for the multicycle CPU. On each rising edge of the core's `instr_change` strobe it records the retiring instruction's PC and IR plus the last register-file write since the previous commit. Records are queued in a parametrised FIFO and streamed out as 4-word packets over a valid/ready interface. This replaces simulation-only `$fdisplay` dumps with hardware that works on silicon and FPGA, including drop accounting when the consumer stalls.

## Interface
- `DATA_W`, 32: width of PC, IR, register data and output word
- `DEPTH`, 16: FIFO depth in records; power of two, ≥2
- `RADDR_W`, 5: register index width
- `CNT_W`, 16: width of drop counter
- `clk_in` in 1: the one clock; all state on rising edge
- `reset` in 1: asynchronous, active-low reset
- `trace_en` in 1: capture enable; commits while low are ignored and not counted as drops
- `instr_change` in 1: commit strobe from the core; rising edge marks a retire
- `pc` in DATA_W: PC of the retiring instruction
- `instr` in DATA_W: IR of the retiring instruction
- `rf_we` in 1: register-file write enable
- `rf_waddr` in RADDR_W: register-file write index
- `rf_wdata` in DATA_W: register-file write data
- `out_data` out DATA_W: packet word
- `out_valid` out 1: `out_data` valid
- `out_ready` in 1: consumer accepts the word when high with `out_valid`
- `out_last` out 1: high on word 3 of a packet
- `level` out $clog2(DEPTH)+1: records currently stored
- `drop_cnt` out CNT_W: saturating count of commits lost to a full FIFO

## Operation
- Edge detect: `chg_q` holds the previous-cycle `instr_change`. A commit is `instr_change & ~chg_q & trace_en`.
- WB tracker: `rf_we` with `rf_waddr != 0` sets `wb_v`, `wb_a` and `wb_d`; a later write overwrites them. At a commit edge the tracker contents are pushed, then cleared. A write on the commit edge itself is loaded into the cleared tracker and belongs to the next record. Writes to r0 are ignored.
- Record contents: {pc, instr, wb_v, wb_a, wb_d}.
- Push: on a commit when `level < DEPTH`, or when `level == DEPTH` and a pop completes on the same edge.
- Drop: on a commit when full and no pop on that edge. `drop_cnt` increments and saturates at all-ones.
- Serializer FSM: IDLE → W0 → W1 → W2 → W3 → (W0 if `level>1` else IDLE).
  - W0 outputs pc.
  - W1 outputs instr.
  - W2 outputs {wb_v, zeros, wb_a}, with wb_v at bit DATA_W-1 and wb_a in the low RADDR_W bits.
  - W3 outputs wb_d and asserts `out_last`.
- FSM advances only on `out_valid & out_ready`. The FIFO head pops on the W3 handshake.
- `out_valid` is high in W0–W3 and low in IDLE. `out_data` and `out_last` hold stable while `out_valid & ~out_ready`.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. `level` is tracked separately, so full and empty are distinguishable.

## Timing
- Reset values: `out_valid`=0, `out_last`=0, `out_data`=0, `level`=0, `drop_cnt`=0, FSM=IDLE, `chg_q`=0, tracker cleared, pointers 0.
- Reset mid-packet discards all queued records; no partial packet completes.
- Push-to-first-word latency: a record pushed into an empty FIFO at edge N presents W0 with `out_valid`=1 after edge N+1.
- Throughput: one word per cycle under continuous `out_ready`. Back-to-back packets run with no IDLE gap.
- `level` updates on the push/pop edge. Simultaneous push and pop leave `level` unchanged.
- A level-high `instr_change` generates exactly one commit. Re-arming needs at least one low cycle.
- `instr_change` high during reset release: `chg_q`=0, so the first sampled cycle with `trace_en`=1 counts as a commit.

## Configuration
- `TRACE_PC_FILTER_EN` defined: adds inputs `filt_lo` and `filt_hi` (DATA_W each). A commit is captured only if `filt_lo <= pc <= filt_hi`, unsigned compare. Filtered-out commits still clear the WB tracker and never count as drops.
- Not defined: those ports do not exist, and every enabled commit is captured.

## Test plan
- Single commit, pc=0x00400000, instr=0x20010005, rf write r1=5 before the edge, `out_ready`=1 → words 0x00400000, 0x20010005, 0x80000001, 0x00000005; `out_last` on word 4; `level` returns to 0.
- Commit with no intervening write; a write to r0 only → W2=0x00000000, W3=0x00000000.
- `out_ready`=0, DEPTH=16, 20 commits → `level`=16, `drop_cnt`=4; then `out_ready`=1 → exactly 16 packets with the first 16 PCs in order.
- Full FIFO with pop on the same edge as a commit → record accepted, `drop_cnt` unchanged, `level` stays 16.
- `out_ready` toggled every cycle mid-packet → `out_data` stable while stalled; no word duplicated or skipped.
- Assert `reset` low during W2 with 3 records queued → next cycle `out_valid`=0, `level`=0; after release, a new commit yields a clean packet starting at W0.
